// File: rtl/mem_fill_engine_if.sv
// Control handshake and RAM write port of the memory fill engine.
// The master side starts runs and observes the RAM writes; the slave side is the engine.
interface mem_fill_engine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              en;
  logic              rdy;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] fill;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wrdata;
  logic              wren;
  logic              done;

  modport master (
    output en, mode, base, count, fill,
    input  rdy, addr, wrdata, wren, done
  );

  modport slave (
    input  en, mode, base, count, fill,
    output rdy, addr, wrdata, wren, done
  );
endinterface

// File: rtl/mem_fill_engine.sv
// Writes a latched run of up to 2**ADDR_W words from base, one per clock, then pulses done.
// All outputs come straight from flops; en is only taken while idle and is never queued.
module mem_fill_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_fill_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [1:0]      M_IDENTITY = 2'b00;
  localparam logic [1:0]      M_FILL     = 2'b01;
  localparam logic [1:0]      M_DESCEND  = 2'b10;
  localparam logic [ADDR_W:0] ONE        = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL       = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   k;

  logic [ADDR_W:0]   cnt_in;
  logic [ADDR_W:0]   k_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  // Zero-extend or truncate an index-width value onto the data bus.
  function automatic logic [DATA_W-1:0] to_data(input logic [ADDR_W:0] v);
    logic [ADDR_W+DATA_W:0] ext;
    ext = {{DATA_W{1'b0}}, v};
    return ext[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] word(
    input logic [1:0]        m,
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] f,
    input logic [ADDR_W:0]   c,
    input logic [ADDR_W:0]   i
  );
    case (m)
      M_IDENTITY: return to_data({1'b0, a});
      M_FILL:     return f;
      M_DESCEND:  return to_data(c - i - ONE);
      default:    return f + to_data(i);
    endcase
  endfunction

  // Requests above full depth collapse to a full-depth run.
  always_comb begin
    cnt_in   = bus.count[ADDR_W] ? FULL : bus.count;
    k_nxt    = k + ONE;
    addr_nxt = base_q + k_nxt[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      k          <= '0;
      cnt_q      <= '0;
      mode_q     <= '0;
      base_q     <= '0;
      fill_q     <= '0;
      bus.rdy    <= 1'b1;
      bus.wren   <= 1'b0;
      bus.done   <= 1'b0;
      bus.addr   <= '0;
      bus.wrdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            mode_q  <= bus.mode;
            base_q  <= bus.base;
            fill_q  <= bus.fill;
            cnt_q   <= cnt_in;
            k       <= '0;
            bus.rdy <= 1'b0;
            if (cnt_in == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state      <= WRITE;
              bus.wren   <= 1'b1;
              bus.addr   <= bus.base;
              bus.wrdata <= word(bus.mode, bus.base, bus.fill, cnt_in, '0);
            end
          end
        end
        WRITE: begin
          if (k == cnt_q - ONE) begin
            state    <= DONE;
            bus.wren <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            k          <= k_nxt;
            bus.addr   <= addr_nxt;
            bus.wrdata <= word(mode_q, addr_nxt, fill_q, cnt_q, k_nxt);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.rdy  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fill_engine.sv
// Directed bench for mem_fill_engine: vector table of whole runs plus reset-abort sequence.
module tb_mem_fill_engine;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] base;
    logic [8:0] count;
    logic [7:0] fill;
    bit         disturb;
    int         exp_writes;
    logic [7:0] exp_last_addr;
    logic [7:0] exp_last_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_fill_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_fill_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int writes, first_w, last_w, dones, done_j, rdy_j, bad, idle_bad;
    logic [7:0] last_a, last_d, a, d;
    string tag;
    tag = $sformatf("v%0d", id);
    writes = 0; first_w = 0; last_w = 0; dones = 0; done_j = 0; rdy_j = 0;
    last_a = '0; last_d = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h5A;
      exp_mem[i] = 8'h5A;
    end
    for (int k = 0; k < v.exp_writes; k++) begin
      a = v.base + k[7:0];
      case (v.mode)
        2'b00:   d = a;
        2'b01:   d = v.fill;
        2'b10:   d = 8'(v.exp_writes - 1 - k);
        default: d = v.fill + k[7:0];
      endcase
      exp_mem[a] = d;
    end
    @(negedge clk);
    chk({tag, "_rdy_before"}, int'(bus.rdy), 1);
    bus.en = 1'b1; bus.mode = v.mode; bus.base = v.base; bus.count = v.count; bus.fill = v.fill;
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      if (bus.wren) begin
        writes++;
        if (first_w == 0) first_w = j;
        last_w = j;
        mem[bus.addr] = bus.wrdata;
        last_a = bus.addr;
        last_d = bus.wrdata;
      end
      if (bus.done) begin
        dones++;
        if (done_j == 0) done_j = j;
      end
      if (bus.rdy) begin
        rdy_j = j;
        break;
      end
      if (j == 1) bus.en = 1'b0;
      if (v.disturb && j == 3) begin
        bus.en = 1'b1; bus.mode = ~v.mode; bus.base = v.base + 8'h33;
        bus.count = 9'd5; bus.fill = ~v.fill;
      end
      if (v.disturb && j == 4) bus.en = 1'b0;
    end
    bus.en = 1'b0;
    chk({tag, "_writes"}, writes, v.exp_writes);
    chk({tag, "_first_write_cycle"}, first_w, (v.exp_writes > 0) ? 1 : 0);
    chk({tag, "_last_write_cycle"}, last_w, v.exp_writes);
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_done_cycle"}, done_j, v.exp_writes + 1);
    chk({tag, "_rdy_cycle"}, rdy_j, v.exp_writes + 2);
    if (v.exp_writes > 0) begin
      chk({tag, "_last_addr"}, int'(last_a), int'(v.exp_last_addr));
      chk({tag, "_last_data"}, int'(last_d), int'(v.exp_last_data));
    end
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== exp_mem[i]) begin
        if (bad == 0)
          $display("  %s first bad word at %0h: got %0h, expected %0h", tag, i, mem[i], exp_mem[i]);
        bad++;
      end
    chk({tag, "_mem_bad_words"}, bad, 0);
    idle_bad = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (bus.wren || bus.done || !bus.rdy) idle_bad++;
    end
    chk({tag, "_idle_after"}, idle_bad, 0);
  endtask

  initial begin
    vec_t vecs [6];
    vec_t again;
    int seen, abort_bad;

    vecs[0] = '{2'b00, 8'h00, 9'd256, 8'h00, 1'b0, 256, 8'hFF, 8'hFF};
    vecs[1] = '{2'b01, 8'hF0, 9'd32,  8'hA5, 1'b1, 32,  8'h0F, 8'hA5};
    vecs[2] = '{2'b10, 8'h10, 9'd4,   8'h00, 1'b0, 4,   8'h13, 8'h00};
    vecs[3] = '{2'b11, 8'h40, 9'd3,   8'hFE, 1'b0, 3,   8'h42, 8'h00};
    vecs[4] = '{2'b01, 8'h20, 9'd0,   8'h11, 1'b0, 0,   8'h00, 8'h00};
    vecs[5] = '{2'b11, 8'h80, 9'd300, 8'h07, 1'b1, 256, 8'h7F, 8'h06};
    again   = '{2'b10, 8'hFE, 9'd5,   8'h00, 1'b0, 5,   8'h02, 8'h00};

    bus.en = 1'b0; bus.mode = '0; bus.base = '0; bus.count = '0; bus.fill = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", int'(bus.rdy), 1);
    chk("reset_wren", int'(bus.wren), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_addr", int'(bus.addr), 0);
    chk("reset_wrdata", int'(bus.wrdata), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Abort a full-depth run after ten writes.
    @(negedge clk);
    bus.en = 1'b1; bus.mode = 2'b00; bus.base = 8'h00; bus.count = 9'd256; bus.fill = 8'h00;
    seen = 0;
    for (int j = 0; j < 50 && seen < 10; j++) begin
      @(negedge clk);
      bus.en = 1'b0;
      if (bus.wren) seen++;
    end
    chk("abort_writes_seen", seen, 10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_wren", int'(bus.wren), 0);
    chk("abort_rdy", int'(bus.rdy), 1);
    chk("abort_done", int'(bus.done), 0);
    rst_n = 1'b1;
    abort_bad = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.wren || bus.done || !bus.rdy) abort_bad++;
    end
    chk("abort_quiet", abort_bad, 0);

    run_vec(6, again);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
